ysyx_220053_div64: RTL

YSYX_220053_DIV64 -- requirements
Module: ysyx_220053_div64

---
 rtl/ysyx_220053_div64.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ysyx_220053_div64.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220053_div64
// Brief   : Iterative restoring 64/32-bit divider, signed and unsigned,
//           with single-cycle divide-by-zero and signed-overflow paths.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_220053_div64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid,
  input  logic        div_signed,
  input  logic        divw,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  input  logic        flush,
  output logic        div_ready,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_next_state;
  logic        r_w, r_q_neg, r_r_neg, r_fast;
  logic [5:0]  r_cnt;
  logic [63:0] r_dvs, r_rem, r_quo;

  logic        w_accept, w_a_neg, w_b_neg, w_dbz, w_ovf, w_ge;
  logic [63:0] w_a_mag, w_b_mag, w_dvd_w;
  logic [64:0] w_sub;
  logic [63:0] w_q_fix, w_r_fix, w_q_out, w_r_out;

  assign div_ready = (r_state == S_IDLE);
  assign w_accept  = div_valid && div_ready && !flush;

  assign w_a_neg = div_signed & (divw ? dividend[31] : dividend[63]);
  assign w_b_neg = div_signed & (divw ? divisor[31]  : divisor[63]);
  assign w_a_mag = divw ? {32'd0, (w_a_neg ? 32'd0 - dividend[31:0] : dividend[31:0])}
                        : (w_a_neg ? 64'd0 - dividend : dividend);
  assign w_b_mag = divw ? {32'd0, (w_b_neg ? 32'd0 - divisor[31:0] : divisor[31:0])}
                        : (w_b_neg ? 64'd0 - divisor : divisor);
  assign w_dvd_w = {{32{dividend[31]}}, dividend[31:0]};

  assign w_dbz = divw ? (divisor[31:0] == 32'd0) : (divisor == 64'd0);
  assign w_ovf = div_signed &
                 (divw ? (dividend[31:0] == 32'h8000_0000 && divisor[31:0] == 32'hFFFF_FFFF)
                       : (dividend == 64'h8000_0000_0000_0000 && divisor == '1));

  // Partial remainder is {r_rem, next dividend bit}; r_rem[63] set means the
  // 65-bit value already exceeds any 64-bit divisor, so the borrow is ignored.
  assign w_sub = {1'b0, r_rem[62:0], r_quo[63]} - {1'b0, r_dvs};
  assign w_ge  = r_rem[63] | ~w_sub[64];

  assign w_q_fix = r_q_neg ? 64'd0 - r_quo : r_quo;
  assign w_r_fix = r_r_neg ? 64'd0 - r_rem : r_rem;
  assign w_q_out = r_fast ? r_quo : (r_w ? {{32{w_q_fix[31]}}, w_q_fix[31:0]} : w_q_fix);
  assign w_r_out = r_fast ? r_rem : (r_w ? {{32{w_r_fix[31]}}, w_r_fix[31:0]} : w_r_fix);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = (w_dbz || w_ovf) ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == 6'd0) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (flush) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      quotient  <= 64'd0;
      remainder <= 64'd0;
      r_w       <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_fast    <= 1'b0;
      r_cnt     <= 6'd0;
      r_dvs     <= 64'd0;
      r_rem     <= 64'd0;
      r_quo     <= 64'd0;
    end else begin
      out_valid <= (r_state == S_DONE) && !flush;
      if (r_state == S_DONE && !flush) begin
        quotient  <= w_q_out;
        remainder <= w_r_out;
      end
      if (w_accept) begin
        r_w     <= divw;
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
        r_dvs   <= w_b_mag;
        r_fast  <= w_dbz | w_ovf;
        r_cnt   <= divw ? 6'd31 : 6'd63;
        if (w_dbz) begin
          r_quo <= '1;
          r_rem <= divw ? w_dvd_w : dividend;
        end else if (w_ovf) begin
          r_quo <= divw ? w_dvd_w : dividend;
          r_rem <= 64'd0;
        end else begin
          // W operands start in the upper half so 32 shifts land the quotient low.
          r_quo <= divw ? {w_a_mag[31:0], 32'd0} : w_a_mag;
          r_rem <= 64'd0;
        end
      end else if (r_state == S_BUSY && !flush) begin
        r_rem <= w_ge ? w_sub[63:0] : {r_rem[62:0], r_quo[63]};
        r_quo <= {r_quo[62:0], w_ge};
        if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
      end
    end
  end

endmodule
`default_nettype wire
